// File: rtl/mod_dcache_lru_if.sv
// Core-side and memory-side handshake bundle of the LRU data cache.
interface mod_dcache_lru_if #(
    parameter int ADDR_W  = 64,
    parameter int BLOCK_W = 512
);
    logic               core_reqcyc;
    logic               core_reqack;
    logic [ADDR_W-1:0]  core_req;
    logic               core_we;
    logic [63:0]        core_wdata;
    logic [7:0]         core_be;
    logic               core_respcyc;
    logic [63:0]        core_resp;
    logic               mem_reqcyc;
    logic               mem_reqack;
    logic [ADDR_W-1:0]  mem_req;
    logic               mem_we;
    logic [BLOCK_W-1:0] mem_reqdata;
    logic               mem_respcyc;
    logic               mem_respack;
    logic [BLOCK_W-1:0] mem_resp;

    // slave is the cache; master is the core plus the memory arbiter around it
    modport slave (
        input  core_reqcyc, core_req, core_we, core_wdata, core_be,
        output core_reqack, core_respcyc, core_resp,
        output mem_reqcyc, mem_req, mem_we, mem_reqdata, mem_respack,
        input  mem_reqack, mem_respcyc, mem_resp
    );

    modport master (
        output core_reqcyc, core_req, core_we, core_wdata, core_be,
        input  core_reqack, core_respcyc, core_resp,
        input  mem_reqcyc, mem_req, mem_we, mem_reqdata, mem_respack,
        output mem_reqack, mem_respcyc, mem_resp
    );
endinterface

// File: rtl/mod_dcache_lru.sv
// N-way set-associative write-back, write-allocate L1 data cache with true-LRU
// replacement; the core reads and writes single 64-bit words under byte enables.
module mod_dcache_lru #(
    parameter int ADDR_W    = 64,
    parameter int LOG_BLOCK = 6,
    parameter int LOG_SETS  = 7,
    parameter int LOG_WAYS  = 2
) (
    input  logic            clk,
    input  logic            reset,
    mod_dcache_lru_if.slave bus
);
    localparam int WAYS    = 1 << LOG_WAYS;
    localparam int SETS    = 1 << LOG_SETS;
    localparam int BLOCK_W = (1 << LOG_BLOCK) * 8;
    localparam int LOG_WPB = LOG_BLOCK - 3;
    localparam int TAG_W   = ADDR_W - LOG_SETS - LOG_BLOCK;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    function automatic logic [63:0] merge_word(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++)
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return res;
    endfunction

    function automatic logic [63:0] get_word(input logic [BLOCK_W-1:0] blk,
                                             input logic [LOG_WPB-1:0] w);
        return blk[int'(w)*64 +: 64];
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_block(input logic [BLOCK_W-1:0] blk,
                                                       input logic [LOG_WPB-1:0] w,
                                                       input logic [63:0]        new_w,
                                                       input logic [7:0]         be);
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[int'(w)*64 +: 64] = merge_word(get_word(blk, w), new_w, be);
        return res;
    endfunction

    logic [BLOCK_W-1:0]  data_mem [WAYS][SETS];
    logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];
    logic [SETS-1:0]     valid_q  [WAYS];
    logic [SETS-1:0]     dirty_q  [WAYS];
    logic [LOG_WAYS-1:0] age_q    [WAYS][SETS];

    logic [2:0]          state;
    logic [TAG_W-1:0]    tag_q;
    logic [LOG_SETS-1:0] idx_q;
    logic [LOG_WPB-1:0]  word_q;
    logic                we_q;
    logic [63:0]         wdata_q;
    logic [7:0]          be_q;
    logic [LOG_WAYS-1:0] way_q;
    logic [LOG_WAYS-1:0] acc_age_q;
    logic [63:0]         core_resp_q;
    logic                mem_reqcyc_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_req_q;
    logic [BLOCK_W-1:0]  mem_reqdata_q;

    logic                hit;
    logic [LOG_WAYS-1:0] hit_way;
    logic                inv_found;
    logic [LOG_WAYS-1:0] inv_way;
    logic [LOG_WAYS-1:0] lru_way;
    logic [LOG_WAYS-1:0] vic_way;
    logic [BLOCK_W-1:0]  hit_blk;

    logic                arr_we;
    logic                tag_we;
    logic [LOG_WAYS-1:0] arr_way;
    logic [BLOCK_W-1:0]  arr_blk;

    logic                unused_offset;
    assign unused_offset = ^bus.core_req[2:0];

    assign bus.core_reqack  = (state == S_IDLE) && bus.core_reqcyc && !reset;
    assign bus.core_respcyc = (state == S_RESP) && !reset;
    assign bus.core_resp    = core_resp_q;
    assign bus.mem_reqcyc   = mem_reqcyc_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_reqdata  = mem_reqdata_q;
    assign bus.mem_respack  = bus.mem_respcyc;

    // Tag match and victim choice: first invalid way wins, else the oldest way
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx_q] && (tag_mem[w][idx_q] == tag_q) && !hit) begin
                hit     = 1'b1;
                hit_way = LOG_WAYS'(w);
            end
            if (!valid_q[w][idx_q] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = LOG_WAYS'(w);
            end
            if (age_q[w][idx_q] == LOG_WAYS'(WAYS - 1))
                lru_way = LOG_WAYS'(w);
        end
        vic_way = inv_found ? inv_way : lru_way;
        hit_blk = data_mem[hit_way][idx_q];
    end

    always_comb begin
        arr_we  = 1'b0;
        tag_we  = 1'b0;
        arr_way = way_q;
        arr_blk = bus.mem_resp;
        if (state == S_LOOKUP && hit && we_q) begin
            arr_we  = 1'b1;
            arr_way = hit_way;
            arr_blk = merge_block(hit_blk, word_q, wdata_q, be_q);
        end else if (state == S_FILL && bus.mem_respcyc) begin
            arr_we  = 1'b1;
            tag_we  = 1'b1;
            arr_blk = we_q ? merge_block(bus.mem_resp, word_q, wdata_q, be_q) : bus.mem_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) data_mem[arr_way][idx_q] <= arr_blk;
        if (tag_we) tag_mem[arr_way][idx_q] <= tag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mem_reqcyc_q <= 1'b0;
            mem_we_q     <= 1'b0;
            core_resp_q  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
                for (int s = 0; s < SETS; s++)
                    age_q[w][s] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.core_reqcyc) begin
                        tag_q   <= bus.core_req[ADDR_W-1 -: TAG_W];
                        idx_q   <= bus.core_req[LOG_BLOCK +: LOG_SETS];
                        word_q  <= bus.core_req[LOG_BLOCK-1:3];
                        we_q    <= bus.core_we;
                        wdata_q <= bus.core_wdata;
                        be_q    <= bus.core_be;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        way_q     <= hit_way;
                        acc_age_q <= age_q[hit_way][idx_q];
                        if (we_q) dirty_q[hit_way][idx_q] <= 1'b1;
                        else      core_resp_q <= get_word(hit_blk, word_q);
                        state     <= S_RESP;
                    end else begin
                        // A freshly installed way ranks as if it had been the oldest
                        way_q        <= vic_way;
                        acc_age_q    <= LOG_WAYS'(WAYS - 1);
                        mem_reqcyc_q <= 1'b1;
                        if (valid_q[vic_way][idx_q] && dirty_q[vic_way][idx_q]) begin
                            mem_we_q      <= 1'b1;
                            mem_req_q     <= {tag_mem[vic_way][idx_q], idx_q, {LOG_BLOCK{1'b0}}};
                            mem_reqdata_q <= data_mem[vic_way][idx_q];
                            state         <= S_WB;
                        end else begin
                            mem_we_q  <= 1'b0;
                            mem_req_q <= {tag_q, idx_q, {LOG_BLOCK{1'b0}}};
                            state     <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_respcyc) begin
                        dirty_q[way_q][idx_q] <= 1'b0;
                        mem_reqcyc_q          <= 1'b1;
                        mem_we_q              <= 1'b0;
                        mem_req_q             <= {tag_q, idx_q, {LOG_BLOCK{1'b0}}};
                        state                 <= S_FILL;
                    end else if (bus.mem_reqack) begin
                        mem_reqcyc_q <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (bus.mem_respcyc) begin
                        valid_q[way_q][idx_q] <= 1'b1;
                        dirty_q[way_q][idx_q] <= we_q;
                        mem_reqcyc_q          <= 1'b0;
                        core_resp_q           <= get_word(arr_blk, word_q);
                        state                 <= S_RESP;
                    end else if (bus.mem_reqack) begin
                        mem_reqcyc_q <= 1'b0;
                    end
                end
                S_RESP: begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (LOG_WAYS'(w) == way_q)
                            age_q[w][idx_q] <= '0;
                        else if (valid_q[w][idx_q] && (age_q[w][idx_q] < acc_age_q))
                            age_q[w][idx_q] <= age_q[w][idx_q] + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_dcache_lru.sv
// Directed bench for mod_dcache_lru: expected core and memory transactions are
// queued by the stimulus and checked by independent monitor processes.
module tb_mod_dcache_lru;
    localparam int ADDR_W  = 64;
    localparam int BLOCK_W = 512;

    logic clk = 1'b0;
    logic reset;

    mod_dcache_lru_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

    mod_dcache_lru #(.ADDR_W(ADDR_W), .LOG_BLOCK(6), .LOG_SETS(7), .LOG_WAYS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic chk; logic [63:0] data; } core_exp_t;
    typedef struct { logic we; logic [63:0] addr; logic [BLOCK_W-1:0] data; } mem_exp_t;

    core_exp_t          core_q[$];
    mem_exp_t           mem_q[$];
    logic [BLOCK_W-1:0] mem_model [logic [63:0]];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   resp_cnt = 0;
    int   resp_cyc = 0;
    int   mem_acc  = 0;
    logic mem_hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Untouched memory holds each word's own byte address
    function automatic logic [BLOCK_W-1:0] dflt_blk(input logic [63:0] a);
        logic [BLOCK_W-1:0] b;
        for (int i = 0; i < 8; i++) b[i*64 +: 64] = {a[63:6], 6'd0} + 64'(i * 8);
        return b;
    endfunction

    function automatic logic [BLOCK_W-1:0] get_blk(input logic [63:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return dflt_blk(a);
    endfunction

    function automatic mem_exp_t mexp(input logic we, input logic [63:0] a, input logic [BLOCK_W-1:0] d);
        mem_exp_t e;
        e.we = we; e.addr = a; e.data = d;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core-side monitor
    initial begin
        core_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.core_respcyc === 1'b1) begin
                resp_cnt++;
                resp_cyc = cyc;
                if (core_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL core_resp unexpected: got respcyc with 0x%0h, expected none", bus.core_resp);
                end else begin
                    e = core_q.pop_front();
                    if (e.chk) check("core_resp", bus.core_resp, e.data);
                end
            end
        end
    end

    // Memory responder and memory-side monitor
    initial begin
        logic               pend;
        int                 dly;
        logic               p_we;
        logic [63:0]        p_addr;
        logic [BLOCK_W-1:0] p_data;
        mem_exp_t           e;
        pend = 1'b0; dly = 0; p_we = 1'b0; p_addr = '0; p_data = '0;
        bus.mem_reqack = 1'b0; bus.mem_respcyc = 1'b0; bus.mem_resp = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_respcyc) check("mem_respack", 64'(bus.mem_respack), 64'd1);
            bus.mem_reqack  = 1'b0;
            bus.mem_respcyc = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                if (dly > 0) dly--;
                else begin
                    pend = 1'b0;
                    if (p_we) mem_model[p_addr] = p_data;
                    else bus.mem_resp = get_blk(p_addr);
                    bus.mem_respcyc = 1'b1;
                end
            end else if (bus.mem_reqcyc === 1'b1 && !mem_hold) begin
                bus.mem_reqack = 1'b1;
                pend = 1'b1; dly = 2;
                p_we = bus.mem_we; p_addr = bus.mem_req; p_data = bus.mem_reqdata;
                mem_acc++;
                if (mem_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mem_req unexpected: got we=%0d addr 0x%0h, expected none", p_we, p_addr);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_we", 64'(p_we), 64'(e.we));
                    check("mem_req", p_addr, e.addr);
                    if (e.we) check_blk("mem_reqdata", p_data, e.data);
                end
            end
        end
    end

    task automatic core_op(input logic [63:0] a, input logic we, input logic [63:0] wd,
                           input logic [7:0] be, input logic [63:0] exp, input bit chk_lat);
        core_exp_t ce;
        int        ack_cyc;
        int        start;
        bit        got;
        ce.chk = !we; ce.data = exp;
        core_q.push_back(ce);
        start = resp_cnt; ack_cyc = 0; got = 1'b0;
        @(negedge clk);
        bus.core_req = a; bus.core_we = we; bus.core_wdata = wd; bus.core_be = be;
        bus.core_reqcyc = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (bus.core_reqack) begin got = 1'b1; ack_cyc = cyc; end
            else @(negedge clk);
        end
        @(negedge clk);
        bus.core_reqcyc = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL reqack_timeout: got no core_reqack for 0x%0h, expected one", a);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
                #2;
                if (resp_cnt > start) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL respcyc_timeout: got no core_respcyc for 0x%0h, expected one", a);
            end else if (chk_lat) begin
                check("hit_latency", 64'(resp_cyc - ack_cyc), 64'd2);
            end
        end
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] exp);
        core_op(a, 1'b0, 64'd0, 8'h00, exp, 1'b0);
    endtask

    task automatic fill_rd(input logic [63:0] a);
        mem_q.push_back(mexp(1'b0, a, '0));
        rd(a, a);
    endtask

    initial begin
        logic [BLOCK_W-1:0] b;
        int                 acc0;
        bit                 got;
        bus.core_reqcyc = 1'b0; bus.core_req = '0; bus.core_we = 1'b0;
        bus.core_wdata = '0; bus.core_be = '0;
        reset = 1'b1;
        mem_model[64'h1000] = 512'hAA;
        repeat (3) @(negedge clk);
        check("rst_core_reqack", 64'(bus.core_reqack), 64'd0);
        check("rst_core_respcyc", 64'(bus.core_respcyc), 64'd0);
        check("rst_mem_reqcyc", 64'(bus.mem_reqcyc), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_core_resp", bus.core_resp, 64'd0);
        reset = 1'b0;

        // Cold read fills, then a repeat read hits with fixed latency
        mem_q.push_back(mexp(1'b0, 64'h1000, '0));
        rd(64'h1000, 64'hAA);
        acc0 = mem_acc;
        core_op(64'h1000, 1'b0, 64'd0, 8'h00, 64'hAA, 1'b1);
        check("hit_no_mem", 64'(mem_acc), 64'(acc0));

        // Partial write hit, read back
        core_op(64'h1008, 1'b1, 64'h1122334455667788, 8'h0F, 64'd0, 1'b1);
        rd(64'h1008, 64'h0000000055667788);
        check("write_hit_no_mem", 64'(mem_acc), 64'(acc0));

        // Set 0: tags 1..4, touch tag 1, tag 5 evicts tag 2 without writeback
        for (int t = 1; t <= 4; t++) fill_rd(64'(t) * 64'h2000);
        rd(64'h2000, 64'h2000);
        fill_rd(64'hA000);
        acc0 = mem_acc;
        rd(64'h2000, 64'h2000);
        check("lru_tag1_kept", 64'(mem_acc), 64'(acc0));
        fill_rd(64'h4000);

        // Set 64: dirty line 0x1000 ages out, writeback precedes the fill
        fill_rd(64'h3000);
        fill_rd(64'h5000);
        fill_rd(64'h7000);
        b = '0;
        b[63:0]   = 64'hAA;
        b[127:64] = 64'h0000000055667788;
        mem_q.push_back(mexp(1'b1, 64'h1000, b));
        fill_rd(64'h9000);
        mem_q.push_back(mexp(1'b0, 64'h1000, '0));
        rd(64'h1008, 64'h0000000055667788);

        // Set 1: write miss allocates and merges, later evicted dirty
        mem_q.push_back(mexp(1'b0, 64'h20040, '0));
        core_op(64'h20048, 1'b1, 64'hDEADBEEFCAFEF00D, 8'hF0, 64'd0, 1'b0);
        acc0 = mem_acc;
        rd(64'h20048, 64'hDEADBEEF00020048);
        check("write_miss_then_hit", 64'(mem_acc), 64'(acc0));
        fill_rd(64'h22040);
        fill_rd(64'h24040);
        fill_rd(64'h26040);
        b = dflt_blk(64'h20040);
        b[127:64] = 64'hDEADBEEF00020048;
        mem_q.push_back(mexp(1'b1, 64'h20040, b));
        fill_rd(64'h28040);

        // Reset while a fill request is outstanding
        mem_hold = 1'b1;
        @(negedge clk);
        bus.core_req = 64'h30000; bus.core_we = 1'b0; bus.core_reqcyc = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.core_reqack) got = 1'b1;
            else @(negedge clk);
        end
        check("abort_reqack", 64'(got), 64'd1);
        @(negedge clk);
        bus.core_reqcyc = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.mem_reqcyc) got = 1'b1;
            else @(negedge clk);
        end
        check("abort_mem_reqcyc", 64'(got), 64'd1);
        check("abort_mem_req", bus.mem_req, 64'h30000);
        check("abort_mem_we", 64'(bus.mem_we), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("reset_drops_reqcyc", 64'(bus.mem_reqcyc), 64'd0);
        check("reset_core_respcyc", 64'(bus.core_respcyc), 64'd0);
        reset = 1'b0;
        mem_hold = 1'b0;

        // Everything is invalid again, so former hits refill
        mem_q.push_back(mexp(1'b0, 64'h1000, '0));
        rd(64'h1000, 64'hAA);
        fill_rd(64'h2000);

        repeat (5) @(negedge clk);
        check("core_queue_drained", 64'(core_q.size()), 64'd0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mod_dcache_lru.md
Name: mod_dcache_lru

Overview:
- Parametrised N-way set-associative write-back, write-allocate L1 data cache with true-LRU replacement and byte-granular word writes.
- Sits between the core data port and the memory arbiter; serves one core request at a time.
- Successor to the fixed 4-way, first-way-evict, whole-block-write dcache: ways, sets and address width are generic, the victim is chosen by LRU, and the core side reads and writes individual 64-bit words.

Parameters:
ADDR_W, 64, physical address width
LOG_BLOCK, 6, log2 block bytes; block = 512 bits, 8 words of 64 bits
LOG_SETS, 7, log2 number of sets
LOG_WAYS, 2, log2 associativity; WAYS = 4
(derived) TAG_W = ADDR_W - LOG_SETS - LOG_BLOCK; WPB = 2^LOG_BLOCK / 8

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
core_reqcyc  in  1  core request valid; held until core_reqack
core_reqack  out  1  one-cycle accept pulse
core_req  in  ADDR_W  byte address
core_we  in  1  1 = write, 0 = read
core_wdata  in  64  write word
core_be  in  8  byte enables for writes
core_respcyc  out  1  one-cycle response pulse (reads and writes)
core_resp  out  64  read word; valid with core_respcyc
mem_reqcyc  out  1  memory request valid; held until mem_reqack
mem_reqack  in  1  arbiter accept
mem_req  out  ADDR_W  block-aligned address
mem_we  out  1  1 = writeback, 0 = fill
mem_reqdata  out  2^LOG_BLOCK*8  writeback block
mem_respcyc  in  1  memory response (fill data or writeback done)
mem_respack  out  1  equals mem_respcyc combinationally
mem_resp  in  2^LOG_BLOCK*8  fill block

Behaviour:
- Address split: offset = req[LOG_BLOCK-1:0]; word = req[LOG_BLOCK-1:3]; index = next LOG_SETS bits; tag = upper TAG_W bits.
- Per way and set: valid, dirty, tag, block data, and a LOG_WAYS-bit age. Age 0 = MRU. Ages within a valid set form a permutation of 0..WAYS-1.
- Reset: all valid, dirty and age bits clear; state IDLE; core_reqack, core_respcyc, mem_reqcyc and mem_we are 0; core_resp is 0. Reset in any state aborts the operation and drops mem_reqcyc the next cycle. The data arrays need no reset.
- IDLE:
  - If core_reqcyc is high, latch addr, we, wdata and be, pulse core_reqack, and go to LOOKUP.
- LOOKUP (one cycle): compare the tag against all valid ways.
  - Hit: perform the access and go to RESP. A write merges wdata into the word under be and sets dirty.
  - Miss, victim selection: the lowest-numbered invalid way; otherwise the way with age = WAYS-1.
  - Miss, victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - Drive mem_reqcyc=1, mem_we=1, mem_req = {victim tag, index, 0}, mem_reqdata = victim block.
  - Drop mem_reqcyc the cycle after mem_reqack.
  - On mem_respcyc, clear the victim's dirty bit and go to FILL.
- FILL:
  - Drive mem_reqcyc=1, mem_we=0, mem_req = block-aligned latched addr.
  - Drop mem_reqcyc after mem_reqack.
  - On mem_respcyc, install mem_resp into the victim way: valid=1, tag=latched tag, dirty=0.
  - If the request was a write, merge wdata under be into the installed block and set dirty=1 in the same cycle.
  - Go to RESP.
- RESP (one cycle):
  - Pulse core_respcyc. For a read, core_resp = the addressed word, including a just-filled word.
  - LRU update on the accessed way: ways with age below the accessed way's age increment; the accessed way's age becomes 0.
  - Return to IDLE.
- Latency:
  - Hit: reqack in cycle T, respcyc in T+2.
  - Clean miss: respcyc 1 cycle after the fill mem_respcyc.
  - Back-to-back requests accepted from RESP+1.
- mem_respcyc while not in WB or FILL is ignored. mem_reqack and mem_respcyc in the same cycle are legal.
- core_be = 0 on a write still counts as an access: LRU updates, dirty is set, data is unchanged.

Test Plan:
- Reset, then read 0x1000 -> FILL with mem_req=0x1000, mem_we=0; return a block with word0 = 0xAA -> core_resp=0xAA; a repeat read gets respcyc exactly 2 cycles after reqack and no mem_reqcyc.
- Write 0x1008, wdata 0x1122334455667788, be 0x0F, on a hit line whose word1 = 0 -> read 0x1008 returns 0x0000000055667788; line dirty.
- Fill all 4 ways of set 0 (tags 1..4), touch tag 1, then miss tag 5 -> tag 2 is evicted; clean victim, so no WB.
- Dirty-victim eviction -> WB at the victim block address with the dirty data, then FILL of the new address, in that order; final read correct.
- Write miss to a cold line -> FILL, merge, respcyc; a later eviction writes back the merged block.
- Assert reset while in FILL with mem_reqcyc high -> mem_reqcyc=0 next cycle; all lines invalid; the next read re-fills.
